// File: rtl/apb_master_nslv.sv
// -----------------------------------------------------------------------------
// apb_master_nslv
//   APB4 master bridging a valid/ready command port onto an APB bus with
//   NUM_SLAVES decoded select lines. The upper SEL_W address bits pick the
//   slave. An index with no slave behind it completes as a decode error
//   without touching the bus. A PREADY watchdog aborts stuck transfers.
//   Back-to-back commands go straight from ACCESS to the next SETUP.
//
// Ports
//   PCLK, PRESETn        clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready is combinational)
//   cmd_write/addr/wdata/strb  command payload
//   rsp_valid            one-cycle completion pulse, registered
//   rsp_rdata/err/timeout  completion status; these hold between pulses
//   PSEL..PSTRB          APB request outputs
//   PRDATA/PREADY/PSLVERR  APB response inputs, already muxed from the
//                          selected slave
// -----------------------------------------------------------------------------
module apb_master_nslv #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLAVES = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   output logic [NUM_SLAVES-1:0]   PSEL,
   output logic                    PENABLE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic                    PWRITE,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);

   localparam int SEL_W  = $clog2(NUM_SLAVES);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_DECERR = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [STRB_W-1:0]     pstrb_q, pstrb_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  rsp_timeout_q, rsp_timeout_d;

   logic [SEL_W-1:0] cmd_idx;
   logic             idx_ok;
   logic             timeout_hit;
   logic             cmd_acc;
   logic             bus_busy;

   assign cmd_idx = cmd_addr[ADDR_WIDTH-1 -: SEL_W];
   // Extra bit keeps the compare correct when NUM_SLAVES is a power of two.
   assign idx_ok  = {1'b0, cmd_idx} < (SEL_W + 1)'(NUM_SLAVES);

   // The last stalled cycle the watchdog allows; the transfer is aborted at its edge.
   assign timeout_hit = (TIMEOUT != 0) && (state_q == S_ACCESS) && !PREADY &&
                        (cnt_q == CNT_LAST);

   assign cmd_ready = (state_q == S_IDLE) ||
                      ((state_q == S_ACCESS) && PREADY && !timeout_hit);
   assign cmd_acc   = cmd_valid && cmd_ready;

   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      paddr_d       = paddr_q;
      pwrite_d      = pwrite_q;
      pwdata_d      = pwdata_q;
      pstrb_d       = pstrb_q;
      cnt_d         = cnt_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;

      case (state_q)
         S_IDLE: ;
         S_SETUP: begin
            state_d = S_ACCESS;
            cnt_d   = '0;
         end
         S_ACCESS: begin
            if (PREADY) begin
               state_d       = S_IDLE;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
               rsp_err_d     = PSLVERR;
               rsp_timeout_d = 1'b0;
            end else if (timeout_hit) begin
               state_d       = S_IDLE;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DECERR: begin
            state_d       = S_IDLE;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      // An accepted command overrides the IDLE return, giving the
      // ACCESS -> SETUP back-to-back path. Decode errors leave the bus
      // registers untouched.
      if (cmd_acc) begin
         if (idx_ok) begin
            state_d  = S_SETUP;
            sel_d    = cmd_idx;
            paddr_d  = cmd_addr;
            pwrite_d = cmd_write;
            pwdata_d = cmd_wdata;
            pstrb_d  = cmd_write ? cmd_strb : '0;
         end else begin
            state_d  = S_DECERR;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q       <= S_IDLE;
         sel_q         <= '0;
         paddr_q       <= '0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         cnt_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         paddr_q       <= paddr_d;
         pwrite_q      <= pwrite_d;
         pwdata_q      <= pwdata_d;
         pstrb_q       <= pstrb_d;
         cnt_q         <= cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   // Select is decoded from state, so an async reset drops it immediately.
   assign bus_busy = (state_q == S_SETUP) || (state_q == S_ACCESS);

   for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_psel
      assign PSEL[i] = bus_busy && (sel_q == SEL_W'(i));
   end

   assign PENABLE     = (state_q == S_ACCESS);
   assign PADDR       = paddr_q;
   assign PWRITE      = pwrite_q;
   assign PWDATA      = pwdata_q;
   assign PSTRB       = pstrb_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_nslv.sv
// -----------------------------------------------------------------------------
// tb_apb_master_nslv
//   Self-checking bench for apb_master_nslv, built with 3 slaves so that
//   index 3 decodes to an error, and TIMEOUT=16. The bench plays both the
//   command source and the APB slave. Expected responses come from a
//   transaction-level model of the completion rules.
// -----------------------------------------------------------------------------
module tb_apb_master_nslv;

   localparam int NSL = 3;
   localparam int TMO = 16;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [2:0]  PSEL;
   logic        PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic [3:0]  PSTRB;

   apb_master_nslv #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(NSL), .TIMEOUT(TMO)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          stall;   // ACCESS cycles with PREADY low; >= TMO means never ready
      logic [31:0] prdata;
      logic        slverr;
   } cmd_t;

   typedef struct {
      logic [2:0]  psel;    // 0 means decode error
      logic [31:0] rdata;
      logic        err;
      logic        to;
   } exp_t;

   typedef struct {
      cmd_t c;
      exp_t e;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge PCLK);
      #1;
   endtask

   // Completion outcome from the transfer rules: decode by top two address
   // bits, watchdog after TMO stalled cycles, read data only on clean reads.
   function automatic exp_t model(input cmd_t c);
      exp_t e;
      int   idx;
      idx = int'(c.addr[31:30]);
      e = '{3'b000, 32'h0, 1'b1, 1'b0};
      if (idx < NSL) begin
         e.psel = 3'(1 << idx);
         if (c.stall >= TMO) begin
            e.err = 1'b1;
            e.to  = 1'b1;
         end else begin
            e.err   = c.slverr;
            e.rdata = (!c.wr && !c.slverr) ? c.prdata : 32'h0;
         end
      end
      return e;
   endfunction

   // One complete transaction starting and ending in IDLE.
   task automatic run(input cmd_t c, input exp_t e);
      logic [3:0] exp_strb;
      logic       rdy;
      exp_strb = c.wr ? c.strb : 4'h0;
      cmd_valid = 1'b1; cmd_write = c.wr; cmd_addr = c.addr;
      cmd_wdata = c.wdata; cmd_strb = c.strb; PREADY = 1'b0;
      @(negedge PCLK);
      chk("idle_ready", 64'(cmd_ready), 64'(1'b1));
      cyc();
      // Scramble the command port: the bus must use the registered copy.
      cmd_valid = 1'b0; cmd_write = ~c.wr; cmd_addr = $urandom;
      cmd_wdata = $urandom; cmd_strb = 4'($urandom);
      if (e.psel == 3'b000) begin
         @(negedge PCLK);
         chk("decerr_bus", 64'({PENABLE, PSEL}), 64'(4'h0));
         chk("decerr_ready", 64'(cmd_ready), 64'(1'b0));
         cyc();
      end else begin
         @(negedge PCLK);
         chk("setup_bus", 64'({PENABLE, PSEL}), 64'({1'b0, e.psel}));
         chk("setup_paddr", 64'(PADDR), 64'(c.addr));
         chk("setup_pwrite", 64'(PWRITE), 64'(c.wr));
         chk("setup_pwdata", 64'(PWDATA), 64'(c.wdata));
         chk("setup_pstrb", 64'(PSTRB), 64'(exp_strb));
         cyc();
         for (int k = 0; k < TMO; k++) begin
            rdy = (k == c.stall);
            PREADY  = rdy;
            PRDATA  = rdy ? c.prdata : $urandom;
            PSLVERR = rdy ? c.slverr : 1'($urandom);
            @(negedge PCLK);
            chk("access_bus", 64'({PENABLE, PSEL}), 64'({1'b1, e.psel}));
            chk("access_paddr", 64'(PADDR), 64'(c.addr));
            chk("access_pwrite", 64'(PWRITE), 64'(c.wr));
            chk("access_pwdata", 64'(PWDATA), 64'(c.wdata));
            chk("access_pstrb", 64'(PSTRB), 64'(exp_strb));
            chk("access_ready", 64'(cmd_ready), 64'(rdy));
            chk("access_no_rsp", 64'(rsp_valid), 64'(1'b0));
            cyc();
            if (rdy) break;
         end
         PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b0;
      end
      @(negedge PCLK);
      chk("rsp_valid", 64'(rsp_valid), 64'(1'b1));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
      chk("rsp_err", 64'(rsp_err), 64'(e.err));
      chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
      chk("post_bus_idle", 64'({PENABLE, PSEL}), 64'(4'h0));
      chk("post_ready", 64'(cmd_ready), 64'(1'b1));
      cyc();
      @(negedge PCLK);
      chk("rsp_pulse_end", 64'(rsp_valid), 64'(1'b0));
      chk("rsp_err_hold", 64'(rsp_err), 64'(e.err));
      cyc();
   endtask

   initial begin
      vec_t tbl[8];
      cmd_t c;
      int   r;

      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_strb = '0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
      PRESETn = 1'b0;

      // Reset state
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      chk("rst_ctrl", 64'({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}), 64'(0));
      chk("rst_paddr", 64'(PADDR), 64'(0));
      chk("rst_pwdata", 64'(PWDATA), 64'(0));
      chk("rst_pstrb", 64'(PSTRB), 64'(0));
      chk("rst_rdata", 64'(rsp_rdata), 64'(0));
      chk("rst_ready", 64'(cmd_ready), 64'(1'b1));
      cyc();
      PRESETn = 1'b1;
      cyc();

      // Directed vectors: {wr, addr, wdata, strb, stall, prdata, slverr}, {psel, rdata, err, to}
      tbl[0] = '{'{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0,  32'h0,         1'b0}, '{3'b001, 32'h0,         1'b0, 1'b0}};
      tbl[1] = '{'{1'b0, 32'h8000_0010, 32'h0,         4'hF, 3,  32'h1234_5678, 1'b0}, '{3'b100, 32'h1234_5678, 1'b0, 1'b0}};
      tbl[2] = '{'{1'b0, 32'hC000_0000, 32'h0,         4'h0, 0,  32'h0,         1'b0}, '{3'b000, 32'h0,         1'b1, 1'b0}};
      tbl[3] = '{'{1'b1, 32'h4000_0008, 32'h0000_55AA, 4'h3, 16, 32'h0,         1'b0}, '{3'b010, 32'h0,         1'b1, 1'b1}};
      tbl[4] = '{'{1'b0, 32'h4000_0020, 32'h0,         4'hF, 1,  32'hCAFE_F00D, 1'b1}, '{3'b010, 32'h0,         1'b1, 1'b0}};
      tbl[5] = '{'{1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'h0, 0,  32'h0,         1'b1}, '{3'b100, 32'h0,         1'b1, 1'b0}};
      tbl[6] = '{'{1'b0, 32'h0000_0FFC, 32'h0,         4'hC, 15, 32'hA5A5_A5A5, 1'b0}, '{3'b001, 32'hA5A5_A5A5, 1'b0, 1'b0}};
      tbl[7] = '{'{1'b1, 32'hFFFF_FFFC, 32'h1111_2222, 4'hF, 0,  32'h0,         1'b0}, '{3'b000, 32'h0,         1'b1, 1'b0}};
      for (int i = 0; i < 8; i++) run(tbl[i].c, tbl[i].e);

      // Back-to-back writes to slave 1 with cmd_valid held.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0000;
      cmd_wdata = 32'hAAAA_0001; cmd_strb = 4'hF; PREADY = 1'b0;
      @(negedge PCLK);
      chk("b2b_accept1", 64'(cmd_ready), 64'(1'b1));
      cyc();
      cmd_addr = 32'h4000_0004; cmd_wdata = 32'hBBBB_0002; cmd_strb = 4'h5;
      @(negedge PCLK);
      chk("b2b_setup1", 64'({PENABLE, PSEL, cmd_ready}), 64'({1'b0, 3'b010, 1'b0}));
      chk("b2b_setup1_data", 64'(PWDATA), 64'(32'hAAAA_0001));
      cyc();
      PREADY = 1'b1;
      @(negedge PCLK);
      chk("b2b_access1", 64'({PENABLE, PSEL, cmd_ready}), 64'({1'b1, 3'b010, 1'b1}));
      cyc();
      cmd_valid = 1'b0; PREADY = 1'b0;
      @(negedge PCLK);
      chk("b2b_setup2", 64'({PENABLE, PSEL}), 64'({1'b0, 3'b010}));
      chk("b2b_setup2_addr", 64'(PADDR), 64'(32'h4000_0004));
      chk("b2b_setup2_data", 64'({PWDATA, PSTRB}), 64'({32'hBBBB_0002, 4'h5}));
      chk("b2b_rsp1", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'(3'b100));
      cyc();
      PREADY = 1'b1;
      @(negedge PCLK);
      chk("b2b_access2", 64'({PENABLE, PSEL, rsp_valid}), 64'({1'b1, 3'b010, 1'b0}));
      cyc();
      PREADY = 1'b0;
      @(negedge PCLK);
      chk("b2b_rsp2", 64'({rsp_valid, rsp_err, PENABLE, PSEL}), 64'({1'b1, 1'b0, 1'b0, 3'b000}));
      cyc();

      // Reset pulse in the middle of ACCESS.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8000_0040;
      cyc();
      cmd_valid = 1'b0;
      cyc();
      @(negedge PCLK);
      chk("mid_access", 64'({PENABLE, PSEL}), 64'({1'b1, 3'b100}));
      #2 PRESETn = 1'b0;
      #1;
      chk("async_drop", 64'({PENABLE, PSEL}), 64'(4'h0));
      chk("async_ready", 64'(cmd_ready), 64'(1'b1));
      cyc();
      PRESETn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge PCLK);
         chk("rst_no_rsp", 64'({rsp_valid, PENABLE, PSEL}), 64'(5'h0));
         cyc();
      end
      run(tbl[1].c, tbl[1].e);

      // Randomized commands against the model.
      for (int n = 0; n < 40; n++) begin
         c.wr     = 1'($urandom);
         c.addr   = {2'($urandom_range(0, 3)), 28'($urandom), 2'b00};
         c.wdata  = $urandom;
         c.strb   = 4'($urandom);
         r        = int'($urandom_range(0, 9));
         c.stall  = (r == 9) ? TMO + int'($urandom_range(0, 2)) : r % 5;
         c.prdata = $urandom;
         c.slverr = ($urandom_range(0, 3) == 0);
         run(c, model(c));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/apb_master_nslv.md
Name: apb_master_nslv

Overview:
- Parametrised APB4 master that bridges a simple valid/ready command port onto an APB bus with NUM_SLAVES decoded select lines.
- Generalises the team's fixed two-slave master:
  - configurable address and data widths
  - N-way address decode, with a decode-error path
  - write strobes driven on the bus
  - back-to-back transfers without returning to IDLE
  - PREADY timeout watchdog
  - registered response port
- Sits between the bus-control logic and the APB slave fabric. PRDATA/PREADY/PSLVERR arrive already muxed from the selected slave.

Parameters:
ADDR_WIDTH, 32, PADDR width; upper SEL_W bits select the slave
DATA_WIDTH, 32, PWDATA/PRDATA width; multiple of 8
NUM_SLAVES, 4, number of PSEL lines, 2..16; SEL_W = clog2(NUM_SLAVES) (localparam)
TIMEOUT, 16, ACCESS cycles allowed with PREADY low before abort; 0 disables

Ports:
PCLK  in  1  clock, rising edge
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  byte strobes
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err  out  1  PSLVERR, decode error or timeout
rsp_timeout  out  1  completion was a timeout abort
PSEL  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  APB access phase
PADDR  out  ADDR_WIDTH  bus address
PWRITE  out  1  bus direction
PWDATA  out  DATA_WIDTH  bus write data
PSTRB  out  DATA_WIDTH/8  bus strobes
PRDATA  in  DATA_WIDTH  read data from selected slave
PREADY  in  1  slave ready
PSLVERR  in  1  slave error, sampled only when PREADY=1 in ACCESS

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0 except cmd_ready=1; timeout counter 0. Reset mid-transfer drops PSEL/PENABLE immediately and emits no response.
- States: IDLE, SETUP, ACCESS, DECERR.
- cmd_ready is combinational: (state==IDLE) | (state==ACCESS & PREADY & no timeout).
- On acceptance, slave index = cmd_addr[ADDR_WIDTH-1 -: SEL_W].
  - Index < NUM_SLAVES: register PADDR/PWRITE/PWDATA; PSTRB = cmd_write ? cmd_strb : 0; go to SETUP.
  - Otherwise: go to DECERR; no PSEL asserted.
- SETUP: PSEL[idx]=1, PENABLE=0; always go to ACCESS next cycle; counter cleared.
- ACCESS: PSEL[idx]=1, PENABLE=1. Address, data, strobe and direction are stable for the whole transfer.
  - PREADY=1: transfer completes. If a command is accepted the same cycle, go to SETUP (or DECERR) with the new command, with PENABLE=0 in that SETUP. Otherwise go to IDLE.
  - PREADY=0: counter increments. When counter==TIMEOUT-1 with PREADY still 0 (TIMEOUT≠0), abort and go to IDLE; no command accepted that cycle.
- DECERR: one cycle, then IDLE.
- Response: registered, rsp_valid=1 the cycle after completion, abort or DECERR.
  - rsp_rdata = PRDATA for a successful read, else 0.
  - rsp_err = PSLVERR | decode error | timeout.
  - rsp_timeout = 1 only on abort.
  - No backpressure; rsp_* other than rsp_valid hold their last value.
- Outside SETUP/ACCESS: PSEL=0, PENABLE=0. PADDR/PWDATA/PSTRB/PWRITE hold their last values.
- PRDATA/PSLVERR are ignored while PREADY=0.

Test Plan:
- Write 0x0000_1004, data 0xDEADBEEF, strb 0xF, PREADY high -> SETUP then ACCESS with PSEL=0001, PSTRB=F; rsp_valid 1 cycle later, rsp_err=0; 3 cycles from cmd accept to rsp_valid.
- Read addr 0x8000_0010 (slave 2), PREADY low for 3 cycles then high with PRDATA=0x1234_5678 -> PSEL=0100 throughout; rsp_rdata=0x12345678; PSTRB=0 during the read.
- Two queued writes to slave 1 (addr 0x4000_0000), cmd_valid held -> second SETUP directly follows the first ACCESS; PENABLE pattern 0,1,0,1; no IDLE cycle between.
- NUM_SLAVES=3, addr 0xC000_0000 -> no PSEL asserted, DECERR, rsp_err=1, rsp_timeout=0.
- TIMEOUT=16, PREADY never asserted -> abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, PSEL drops the cycle after abort.
- PRESETn pulsed low mid-ACCESS -> PSEL/PENABLE 0 asynchronously, no rsp_valid, next command runs normally; PSLVERR=1 with PREADY on a read -> rsp_err=1, rsp_rdata=0.
